hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised hazard unit for the pipelined RISC-V core. It tracks in-flight destination registers across a configurable number of post-decode stages and replaces fixed forwarding and hazard logic with one unit. It produces per-operand forwarding selects, load-use stalls and a multi-cycle branch/jump flush. It sits in the Controller between the ID-stage decode signals and the Datapath stage registers.

Parameters:
ADDR_W, 5, register-address width
DEPTH, 3, tracked stages after ID (index 0 = EX, 1 = MEM, 2 = WB)
NUM_SRC, 2, source operands checked per instruction
LOAD_LAT, 1, load data is forwardable only from stage index >= LOAD_LAT
FLUSH_CYC, 2, cycles flush is held after a redirect (kills IF and ID)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
id_valid  in  1  ID holds a real instruction
id_rs  in  NUM_SRC*ADDR_W  packed source addresses; operand i at [i*ADDR_W +: ADDR_W]
id_rs_used  in  NUM_SRC  operand i is actually read
id_rd  in  ADDR_W  ID destination
id_reg_we  in  1  ID writes the register file
id_mem_read  in  1  ID is a load
redirect  in  1  taken branch/jump resolved in EX this cycle
fwd_sel  out  NUM_SRC*SELW  per-operand select; 0 = register file, k+1 = stage k; SELW = $clog2(DEPTH+1)
stall  out  1  hold PC and IF/ID
if_we  out  1  PC/IF-ID write enable, equal to !stall
flush  out  1  squash IF/ID contents

Behaviour:
- State: DEPTH entries {valid, rd, we, is_load}, plus flush counter fcnt (0..FLUSH_CYC).
- Reset (rst low, asynchronous): all entries invalid, fcnt = 0. This gives stall = 0, if_we = 1, flush = 0, fwd_sel = 0.
- Match for operand i at stage k: id_rs_used[i] and entry[k].valid and entry[k].we and entry[k].rd == rs_i and rs_i != 0.
  - Register x0 never matches.
- fwd_sel[i] = smallest matching k plus 1; 0 if nothing matches. The youngest producer wins.
- Load-use: stall = id_valid and !flush and some operand's youngest match has is_load and k < LOAD_LAT. Stall is combinational, same cycle.
- Advance every cycle:
  - entry[k+1] <= entry[k].
  - entry[0] <= ID instruction if id_valid and !stall and !flush; otherwise a bubble (valid = 0).
  - The entry at the last index retires.
- A repeated stall inserts bubbles until the load reaches index LOAD_LAT. With LOAD_LAT = 1, a back-to-back load-use costs exactly 1 cycle.
- Redirect:
  - fcnt <= FLUSH_CYC. flush = (fcnt != 0) or redirect.
  - fcnt decrements to 0 while nonzero.
  - Redirect while fcnt != 0 reloads fcnt to FLUSH_CYC.
- Redirect and load-use in the same cycle: redirect wins. stall = 0, if_we = 1, entry[0] gets a bubble.
- Entries at index >= 0 are not cleared by redirect; they are older and already committed to the path.
- fwd_sel is a don't-care when id_valid = 0 but must still follow the match rules.
- Reset asserted mid-operation clears everything immediately. On the first cycle after release, no forwarding or stall is possible.

Optional Feature:
HAZ_PERF_EN
- Defined: adds outputs perf_stall_cnt [31:0] and perf_flush_cnt [31:0].
  - perf_stall_cnt increments on each stall cycle; perf_flush_cnt on each flush cycle.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: neither the ports nor the counters exist. Behaviour is otherwise identical.

Decomposition:
- Package haz_pkg:
  - typedef haz_entry_t {valid, rd, we, is_load}.
  - constant SEL_RF = 0.
  - helper function for SELW.
- Sub-module hazard_fwd_match: one operand's priority comparator over the entry array. Outputs fwd select and load-hit-too-early. Instantiated NUM_SRC times via generate.

Test Plan:
- add x5 then add x6,x5,x1 back-to-back -> fwd_sel[0] = 1, stall = 0.
- add x5, nop, sub x7,x5,x5 -> fwd_sel[0] = fwd_sel[1] = 2.
- lw x5 then add x6,x5,x0 -> stall = 1, if_we = 0 for exactly 1 cycle. Next cycle fwd_sel[0] = 2, stall = 0.
- Write to x0 followed by a read of x0 -> fwd_sel = 0, no stall.
- Pending producer of x5 at MEM; writes x5 at EX -> fwd_sel = 1 (youngest wins).
- Redirect pulsed 1 cycle with a load-use present -> flush high 3 cycles (redirect cycle + FLUSH_CYC), stall = 0, bubbles enter EX.
- Assert rst low mid-stall -> stall = 0, flush = 0, if_we = 1 immediately. Perf counters read 0 when HAZ_PERF_EN is defined.

Source files
------------

// File: rtl/haz_pkg.sv
// Shared types and helpers for the hazard scoreboard: tracked-entry layout,
// the register-file select code and the select-width helper.
package haz_pkg;

  // Widest register address an entry can hold; narrower addresses are zero-extended.
  localparam int HAZ_RD_W = 8;

  localparam int SEL_RF = 0;

  typedef struct packed {
    logic                valid;
    logic [HAZ_RD_W-1:0] rd;
    logic                we;
    logic                is_load;
  } haz_entry_t;

  function automatic int sel_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_fwd_match.sv
// Priority comparator for one source operand: picks the youngest tracked producer
// and flags a load that is still too young to forward from.
module hazard_fwd_match
  import haz_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int SELW     = 2
) (
  input  logic [ADDR_W-1:0] rs_i,
  input  logic              used_i,
  input  haz_entry_t        entries_i [DEPTH],
  output logic [SELW-1:0]   sel_o,
  output logic              load_early_o
);

  logic [HAZ_RD_W-1:0] rs_ext;
  assign rs_ext = HAZ_RD_W'(rs_i);

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    sel_o        = SELW'(SEL_RF);
    load_early_o = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (used_i && (rs_i != '0) && entries_i[k].valid && entries_i[k].we &&
          (entries_i[k].rd == rs_ext)) begin
        sel_o        = SELW'(k + 1);
        load_early_o = entries_i[k].is_load && (k < LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit: tracks in-flight destinations, drives forwarding selects, load-use
// stall and redirect flush. Optional perf counters guarded by HAZ_PERF_EN.
module hazard_scoreboard
  import haz_pkg::*;
#(
  parameter int ADDR_W    = 5,
  parameter int DEPTH     = 3,
  parameter int NUM_SRC   = 2,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 2,
  localparam int SELW     = sel_w(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_SRC*ADDR_W-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [ADDR_W-1:0]         id_rd,
  input  logic                      id_reg_we,
  input  logic                      id_mem_read,
  input  logic                      redirect,
  output logic [NUM_SRC*SELW-1:0]   fwd_sel,
  output logic                      stall,
  output logic                      if_we,
  output logic                      flush
`ifdef HAZ_PERF_EN
  ,
  output logic [31:0]               perf_stall_cnt,
  output logic [31:0]               perf_flush_cnt
`endif
);

  localparam int FCW = (FLUSH_CYC > 0) ? $clog2(FLUSH_CYC + 1) : 1;

  haz_entry_t         entries_q [DEPTH];
  haz_entry_t         entries_d [DEPTH];
  logic [FCW-1:0]     fcnt_q, fcnt_d;
  logic [NUM_SRC-1:0] load_early;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      hazard_fwd_match #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .LOAD_LAT(LOAD_LAT),
        .SELW    (SELW)
      ) u_match (
        .rs_i        (id_rs[gi*ADDR_W +: ADDR_W]),
        .used_i      (id_rs_used[gi]),
        .entries_i   (entries_q),
        .sel_o       (fwd_sel[gi*SELW +: SELW]),
        .load_early_o(load_early[gi])
      );
    end
  endgenerate

  // Redirect dominates: it forces flush, which masks the stall and bubbles EX.
  always_comb begin
    flush = redirect || (fcnt_q != '0);
    stall = id_valid && !flush && (|load_early);
    if_we = !stall;

    if (redirect)
      fcnt_d = FCW'(FLUSH_CYC);
    else if (fcnt_q != '0)
      fcnt_d = fcnt_q - FCW'(1);
    else
      fcnt_d = fcnt_q;

    entries_d[0].valid   = id_valid && !stall && !flush;
    entries_d[0].rd      = HAZ_RD_W'(id_rd);
    entries_d[0].we      = id_reg_we;
    entries_d[0].is_load = id_mem_read;
    for (int k = 1; k < DEPTH; k++) begin
      entries_d[k] = entries_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        entries_q[k] <= '0;
      end
    end else begin
      fcnt_q <= fcnt_d;
      for (int k = 0; k < DEPTH; k++) begin
        entries_q[k] <= entries_d[k];
      end
    end
  end

`ifdef HAZ_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall && (perf_stall_q != 32'hFFFF_FFFF))
        perf_stall_q <= perf_stall_q + 32'd1;
      if (flush && (perf_flush_q != 32'hFFFF_FFFF))
        perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed pipeline scenarios plus
// randomized traffic against a history-based reference model.
module tb_hazard_scoreboard;

  localparam int ADDR_W    = 5;
  localparam int DEPTH     = 3;
  localparam int NUM_SRC   = 2;
  localparam int LOAD_LAT  = 1;
  localparam int FLUSH_CYC = 2;
  localparam int SELW      = 2;

  logic                      clk;
  logic                      rst;
  logic                      id_valid;
  logic [NUM_SRC*ADDR_W-1:0] id_rs;
  logic [NUM_SRC-1:0]        id_rs_used;
  logic [ADDR_W-1:0]         id_rd;
  logic                      id_reg_we;
  logic                      id_mem_read;
  logic                      redirect;
  logic [NUM_SRC*SELW-1:0]   fwd_sel;
  logic                      stall;
  logic                      if_we;
  logic                      flush;
`ifdef HAZ_PERF_EN
  logic [31:0]               perf_stall_cnt;
  logic [31:0]               perf_flush_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  hazard_scoreboard #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .NUM_SRC  (NUM_SRC),
    .LOAD_LAT (LOAD_LAT),
    .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rs_used (id_rs_used),
    .id_rd      (id_rd),
    .id_reg_we  (id_reg_we),
    .id_mem_read(id_mem_read),
    .redirect   (redirect),
    .fwd_sel    (fwd_sel),
    .stall      (stall),
    .if_we      (if_we),
    .flush      (flush)
`ifdef HAZ_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the list of instructions issued into EX, newest first.
  typedef struct {
    bit valid;
    int rd;
    bit we;
    bit ld;
  } issued_t;

  issued_t hist[$];
  int      cyc;
  int      last_redir;
  int      m_stall_cnt;
  int      m_flush_cnt;
  int      exp_sel[NUM_SRC];
  bit      exp_stall;
  bit      exp_flush;

  task automatic model_reset();
    issued_t b;
    b.valid = 0; b.rd = 0; b.we = 0; b.ld = 0;
    hist.delete();
    for (int k = 0; k < DEPTH; k++) hist.push_back(b);
    cyc = 0;
    last_redir = -1000;
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask

  task automatic model_eval();
    bit early;
    int rs;
    early = 0;
    exp_flush = redirect || ((cyc - last_redir) <= FLUSH_CYC);
    for (int i = 0; i < NUM_SRC; i++) begin
      rs = int'(id_rs[i*ADDR_W +: ADDR_W]);
      exp_sel[i] = 0;
      if (id_rs_used[i] && rs != 0) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (hist[k].valid && hist[k].we && hist[k].rd == rs) begin
            exp_sel[i] = k + 1;
            if (hist[k].ld && k < LOAD_LAT) early = 1;
            break;
          end
        end
      end
    end
    exp_stall = id_valid && !exp_flush && early;
  endtask

  task automatic model_advance();
    issued_t n;
    n.valid = id_valid && !exp_stall && !exp_flush;
    n.rd = int'(id_rd);
    n.we = id_reg_we;
    n.ld = id_mem_read;
    hist.push_front(n);
    void'(hist.pop_back());
    if (redirect) last_redir = cyc;
    if (exp_stall) m_stall_cnt++;
    if (exp_flush) m_flush_cnt++;
    cyc++;
  endtask

  // Apply one ID-stage instruction just after a rising edge, return at the falling edge.
  task automatic step(input bit v, input int rs0, input int rs1, input bit [1:0] used,
                      input int rd, input bit we, input bit mr, input bit red);
    @(posedge clk);
    #1;
    id_valid    = v;
    id_rs       = {ADDR_W'(rs1), ADDR_W'(rs0)};
    id_rs_used  = used;
    id_rd       = ADDR_W'(rd);
    id_reg_we   = we;
    id_mem_read = mr;
    redirect    = red;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 2'b00, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    id_valid = 0; id_rs = '0; id_rs_used = '0; id_rd = '0;
    id_reg_we = 0; id_mem_read = 0; redirect = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (stall !== 1'b0 || if_we !== 1'b1 || flush !== 1'b0 || fwd_sel !== '0) begin
      n_fail++;
      $display("FAIL reset_state: stall=%b if_we=%b flush=%b fwd_sel=%h required 0/1/0/0",
               stall, if_we, flush, fwd_sel);
    end
`ifdef HAZ_PERF_EN
    n_cmp++;
    if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_perf: stall_cnt=%0d flush_cnt=%0d required 0/0",
               perf_stall_cnt, perf_flush_cnt);
    end
`endif
    $display("test_reset: done");
  endtask

  task automatic test_fwd_ex();
    idle(4);
    step(1, 1, 2, 2'b11, 5, 1, 0, 0);
    step(1, 5, 1, 2'b11, 6, 1, 0, 0);
    n_cmp++;
    if (fwd_sel !== 4'b00_01 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_ex: fwd_sel=%b stall=%b required 0001/0", fwd_sel, stall);
    end
    $display("test_fwd_ex: add x5; add x6,x5,x1 fwd_sel=%b", fwd_sel);
  endtask

  task automatic test_fwd_mem();
    idle(4);
    step(1, 1, 2, 2'b11, 5, 1, 0, 0);
    step(0, 0, 0, 2'b00, 0, 0, 0, 0);
    step(1, 5, 5, 2'b11, 7, 1, 0, 0);
    n_cmp++;
    if (fwd_sel !== 4'b10_10 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_mem: fwd_sel=%b stall=%b required 1010/0", fwd_sel, stall);
    end
    $display("test_fwd_mem: add x5; nop; sub x7,x5,x5 fwd_sel=%b", fwd_sel);
  endtask

  task automatic test_load_use();
    idle(4);
    step(1, 1, 2, 2'b11, 5, 1, 1, 0);
    step(1, 5, 0, 2'b11, 6, 1, 0, 0);
    n_cmp++;
    if (stall !== 1'b1 || if_we !== 1'b0 || fwd_sel !== 4'b00_01) begin
      n_fail++;
      $display("FAIL load_use_stall: stall=%b if_we=%b fwd_sel=%b required 1/0/0001",
               stall, if_we, fwd_sel);
    end
    step(1, 5, 0, 2'b11, 6, 1, 0, 0);
    n_cmp++;
    if (stall !== 1'b0 || if_we !== 1'b1 || fwd_sel !== 4'b00_10) begin
      n_fail++;
      $display("FAIL load_use_release: stall=%b if_we=%b fwd_sel=%b required 0/1/0010",
               stall, if_we, fwd_sel);
    end
    step(1, 6, 5, 2'b11, 7, 1, 0, 0);
    n_cmp++;
    if (stall !== 1'b0 || fwd_sel !== 4'b11_01) begin
      n_fail++;
      $display("FAIL load_use_after: stall=%b fwd_sel=%b required 0/1101", stall, fwd_sel);
    end
    $display("test_load_use: lw x5; add x6,x5,x0 one-cycle stall checked");
  endtask

  task automatic test_x0();
    idle(4);
    step(1, 1, 2, 2'b11, 0, 1, 1, 0);
    step(1, 0, 0, 2'b11, 3, 1, 0, 0);
    n_cmp++;
    if (fwd_sel !== 4'b00_00 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_never_matches: fwd_sel=%b stall=%b required 0000/0", fwd_sel, stall);
    end
    $display("test_x0: write x0 then read x0 fwd_sel=%b", fwd_sel);
  endtask

  task automatic test_youngest();
    idle(4);
    step(1, 1, 2, 2'b11, 5, 1, 0, 0);
    step(1, 2, 3, 2'b11, 5, 1, 0, 0);
    step(1, 5, 5, 2'b11, 8, 1, 0, 0);
    n_cmp++;
    if (fwd_sel !== 4'b01_01) begin
      n_fail++;
      $display("FAIL youngest_wins: fwd_sel=%b required 0101", fwd_sel);
    end
    $display("test_youngest: MEM and EX both write x5 fwd_sel=%b", fwd_sel);
  endtask

  task automatic test_redirect();
    idle(4);
    step(1, 1, 2, 2'b11, 5, 1, 1, 0);
    step(1, 5, 5, 2'b11, 6, 1, 0, 1);
    n_cmp++;
    if (stall !== 1'b0 || if_we !== 1'b1 || flush !== 1'b1) begin
      n_fail++;
      $display("FAIL redirect_wins: stall=%b if_we=%b flush=%b required 0/1/1",
               stall, if_we, flush);
    end
    step(1, 6, 5, 2'b11, 7, 1, 0, 0);
    n_cmp++;
    if (flush !== 1'b1 || fwd_sel !== 4'b10_00) begin
      n_fail++;
      $display("FAIL redirect_hold1: flush=%b fwd_sel=%b required 1/1000", flush, fwd_sel);
    end
    step(1, 6, 5, 2'b11, 7, 1, 0, 0);
    n_cmp++;
    if (flush !== 1'b1) begin
      n_fail++;
      $display("FAIL redirect_hold2: flush=%b required 1", flush);
    end
    step(1, 1, 2, 2'b11, 7, 1, 0, 0);
    n_cmp++;
    if (flush !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_end: flush=%b required 0", flush);
    end
    $display("test_redirect: flush held 3 cycles, load-use masked");
  endtask

  task automatic test_reset_midstall();
    idle(4);
    step(1, 1, 2, 2'b11, 5, 1, 1, 0);
    step(1, 5, 2, 2'b11, 6, 1, 0, 0);
    n_cmp++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL midstall_pre: stall=%b required 1", stall);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (stall !== 1'b0 || if_we !== 1'b1 || flush !== 1'b0 || fwd_sel !== '0) begin
      n_fail++;
      $display("FAIL midstall_reset: stall=%b if_we=%b flush=%b fwd_sel=%b required 0/1/0/0",
               stall, if_we, flush, fwd_sel);
    end
`ifdef HAZ_PERF_EN
    n_cmp++;
    if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL midstall_perf: stall_cnt=%0d flush_cnt=%0d required 0/0",
               perf_stall_cnt, perf_flush_cnt);
    end
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b0 || fwd_sel !== '0) begin
      n_fail++;
      $display("FAIL post_release: stall=%b fwd_sel=%b required 0/0", stall, fwd_sel);
    end
    $display("test_reset_midstall: async reset cleared stall");
  endtask

  task automatic test_random();
    int nbad;
    do_reset();
    model_reset();
    nbad = 0;
    for (int t = 0; t < 400; t++) begin
      step(($urandom_range(0, 7) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
           2'($urandom_range(0, 3)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 11) == 0));
      model_eval();
      for (int i = 0; i < NUM_SRC; i++) begin
        n_cmp++;
        if (int'(fwd_sel[i*SELW +: SELW]) !== exp_sel[i]) begin
          n_fail++;
          nbad++;
          $display("FAIL rand_fwd[%0d] cyc=%0d: got %0d required %0d",
                   i, cyc, fwd_sel[i*SELW +: SELW], exp_sel[i]);
        end
      end
      n_cmp++;
      if (stall !== exp_stall || if_we !== !exp_stall || flush !== exp_flush) begin
        n_fail++;
        nbad++;
        $display("FAIL rand_ctl cyc=%0d: stall=%b if_we=%b flush=%b required %b/%b/%b",
                 cyc, stall, if_we, flush, exp_stall, !exp_stall, exp_flush);
      end
      model_advance();
    end
    @(posedge clk);
    #1;
`ifdef HAZ_PERF_EN
    n_cmp++;
    if (perf_stall_cnt !== 32'(m_stall_cnt) || perf_flush_cnt !== 32'(m_flush_cnt)) begin
      n_fail++;
      $display("FAIL rand_perf: stall_cnt=%0d flush_cnt=%0d required %0d/%0d",
               perf_stall_cnt, perf_flush_cnt, m_stall_cnt, m_flush_cnt);
    end
`endif
    $display("test_random: 400 cycles, stalls=%0d flushes=%0d errors=%0d",
             m_stall_cnt, m_flush_cnt, nbad);
  endtask

  initial begin
    rst = 1'b0;
    id_valid = 0; id_rs = '0; id_rs_used = '0; id_rd = '0;
    id_reg_we = 0; id_mem_read = 0; redirect = 0;
    test_reset();
    test_fwd_ex();
    test_fwd_mem();
    test_load_use();
    test_x0();
    test_youngest();
    test_redirect();
    test_reset_midstall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
